// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared types and default widths for the inter-stage pipeline registers.
//   stage_ctrl_t is the layout of the 4-bit control bundle carried between
//   stages. It is listed MSB first: mem_to_reg[1:0], mem_write, reg_write.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int CTRL_W_DEF = 4;
  localparam int RD_W_DEF   = 5;

  typedef struct packed {
    logic [1:0] mem_to_reg;
    logic       mem_write;
    logic       reg_write;
  } stage_ctrl_t;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// ---------------------------------------------------------------------------
// pipe_slot
//   One pipeline entry: a valid bit plus ctrl/rd/data payload.
//   Priority on each edge is reset, then clear, then load.
//   A clear drops only the valid bit. The payload is kept because the stage
//   masks it downstream whenever the entry is not valid.
// Ports
//   clk, reset      clock, synchronous active-low reset
//   i_load          capture i_ctrl/i_rd/i_data and mark the entry valid
//   i_clr           invalidate the entry (wins over i_load)
//   i_ctrl/rd/data  payload to capture
//   o_valid         entry holds a beat
//   o_ctrl/rd/data  stored payload
// ---------------------------------------------------------------------------
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 4,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [RD_W-1:0]   i_rd,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [RD_W-1:0]   o_rd,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [RD_W-1:0]   r_rd;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_rd    <= i_rd;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_rd    = r_rd;
  assign o_data  = r_data;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register with a valid/ready handshake, stall hold,
//   flush (bubble insertion) and an optional 2-entry skid mode.
//   With SKID=1, in_ready comes straight from a register.
//   The stage also counts stall cycles, saturating, for performance debug.
// Ports
//   clk, reset          clock, synchronous active-low reset
//   flush               kill all held beats and the beat accepted this cycle
//   in_valid/in_ready   upstream handshake
//   in_ctrl/rd/data     upstream payload
//   out_valid/out_ready downstream handshake
//   out_ctrl/rd         payload, forced to zero when out_valid=0
//   out_data            payload, meaningful only when out_valid=1
//   cnt_clr             clear stall_cnt (wins over increment)
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              w_accept;
  logic              w_deliver;

  logic              w_main_load;
  logic              w_main_clr;
  logic [CTRL_W-1:0] w_main_ld_ctrl;
  logic [RD_W-1:0]   w_main_ld_rd;
  logic [DATA_W-1:0] w_main_ld_data;

  logic              w_main_valid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [RD_W-1:0]   w_main_rd;
  logic [DATA_W-1:0] w_main_data;

  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_accept  = in_valid & in_ready;
  assign w_deliver = w_main_valid & out_ready;

  // MAIN always drives the outputs
  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .RD_W   (RD_W)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clr   (w_main_clr),
    .i_ctrl  (w_main_ld_ctrl),
    .i_rd    (w_main_ld_rd),
    .i_data  (w_main_ld_data),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_rd    (w_main_rd),
    .o_data  (w_main_data)
  );

  generate
    if (SKID == 0) begin : g_single

      assign in_ready       = ~w_main_valid | out_ready;
      assign w_main_load    = w_accept;
      // flush has priority inside the slot, so a beat accepted in the
      // flush cycle is dropped
      assign w_main_clr     = flush | (w_deliver & ~w_accept);
      assign w_main_ld_ctrl = in_ctrl;
      assign w_main_ld_rd   = in_rd;
      assign w_main_ld_data = in_data;

    end else begin : g_skid

      logic              w_skid_valid;
      logic [CTRL_W-1:0] w_skid_ctrl;
      logic [RD_W-1:0]   w_skid_rd;
      logic [DATA_W-1:0] w_skid_data;
      logic              w_skid_load;
      logic              w_skid_clr;

      // A beat is parked in SKID only while MAIN is stalled. SKID is
      // always empty on such a cycle, because in_ready is !skid_valid.
      assign w_skid_load = w_accept & w_main_valid & ~out_ready;
      assign w_skid_clr  = flush | (w_deliver & w_skid_valid);

      pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .RD_W   (RD_W)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_ctrl  (in_ctrl),
        .i_rd    (in_rd),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_rd    (w_skid_rd),
        .o_data  (w_skid_data)
      );

      assign in_ready = ~w_skid_valid;

      // While SKID is occupied, in_ready is low, so MAIN can only refill
      // from SKID. Otherwise MAIN takes the input beat when it is empty or
      // is being drained this cycle.
      assign w_main_load    = w_skid_valid ? w_deliver
                                           : (w_accept & (~w_main_valid | w_deliver));
      assign w_main_clr     = flush | (w_deliver & ~w_main_load);
      assign w_main_ld_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
      assign w_main_ld_rd   = w_skid_valid ? w_skid_rd   : in_rd;
      assign w_main_ld_data = w_skid_valid ? w_skid_data : in_data;

    end
  endgenerate

  // Bubbles carry no control, so no stray reg/mem write leaks downstream
  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : '0;
  assign out_rd    = w_main_valid ? w_main_rd   : '0;
  assign out_data  = w_main_data;

  // The counter ignores flush; only reset and cnt_clr clear it
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready, cnt_clr;
  logic [3:0]  in_ctrl;
  logic [4:0]  in_rd;
  logic [63:0] in_data;

  logic [1:0]  ov, ir;
  logic [3:0]  oc  [2];
  logic [4:0]  orr [2];
  logic [63:0] od  [2];
  logic [15:0] sc0;
  logic [3:0]  sc1;

  // instance 0: single register, 16-bit counter; instance 1: skid, 4-bit counter
  pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .RD_W(5), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_rd(orr[0]), .out_data(od[0]),
    .cnt_clr(cnt_clr), .stall_cnt(sc0));

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .RD_W(5), .SKID(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_rd(orr[1]), .out_data(od[1]),
    .cnt_clr(cnt_clr), .stall_cnt(sc1));

  // Reference model: each stage is an in-order FIFO of capacity 1 or 2.
  typedef struct packed {
    logic [3:0]  c;
    logic [4:0]  r;
    logic [63:0] d;
  } beat_t;

  beat_t mb [2][2];
  int    mn [2];
  int    mcnt [2];
  int    mmax [2];

  int n_chk, n_pass;
  bit chk_en;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic bit m_ready(int k);
    if (k == 1) return mn[k] < 2;
    return (mn[k] == 0) || out_ready;
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [63:0] scv;
      scv = (k == 0) ? 64'(sc0) : 64'(sc1);
      chk($sformatf("out_valid%0d", k), 64'(ov[k]), 64'(mn[k] > 0));
      chk($sformatf("in_ready%0d", k), 64'(ir[k]), 64'(m_ready(k)));
      chk($sformatf("out_ctrl%0d", k), 64'(oc[k]), (mn[k] > 0) ? 64'(mb[k][0].c) : 64'd0);
      chk($sformatf("out_rd%0d", k), 64'(orr[k]), (mn[k] > 0) ? 64'(mb[k][0].r) : 64'd0);
      if (mn[k] > 0) chk($sformatf("out_data%0d", k), od[k], mb[k][0].d);
      chk($sformatf("stall_cnt%0d", k), scv, 64'(mcnt[k]));
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit v, rdy;
      v   = mn[k] > 0;
      rdy = m_ready(k);
      if (!reset) begin
        mn[k]   = 0;
        mcnt[k] = 0;
      end else begin
        if (cnt_clr) mcnt[k] = 0;
        else if (v && !out_ready && mcnt[k] < mmax[k]) mcnt[k]++;
        if (flush) mn[k] = 0;
        else begin
          if (v && out_ready) begin
            mb[k][0] = mb[k][1];
            mn[k]--;
          end
          if (in_valid && rdy) begin
            mb[k][mn[k]] = {in_ctrl, in_rd, in_data};
            mn[k]++;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit rst_n, input bit fl, input bit iv, input logic [3:0] ic,
                     input logic [4:0] ird, input logic [63:0] id, input bit ordy, input bit clr);
    @(negedge clk);
    reset     = rst_n;
    flush     = fl;
    in_valid  = iv;
    in_ctrl   = ic;
    in_rd     = ird;
    in_data   = id;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    if (chk_en) check_all();
    model_step();
  endtask

  initial begin
    stage_ctrl_t rc;
    n_chk = 0; n_pass = 0; chk_en = 0;
    mn[0] = 0; mn[1] = 0; mcnt[0] = 0; mcnt[1] = 0;
    mmax[0] = 65535; mmax[1] = 15;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_ctrl = '0; in_rd = '0; in_data = '0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_in_ready0", 64'(ir[0]), 64'd1);
    chk("rst_in_ready1", 64'(ir[1]), 64'd1);
    chk("rst_stall0", 64'(sc0), 64'd0);

    // stream 8 beats
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 1, 4'h5, 5'd3, 64'(i), 1, 0);
      if (i > 1) begin
        chk("stream0", od[0], 64'(i - 1));
        chk("stream1", od[1], 64'(i - 1));
      end
    end
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("stream_last0", od[0], 64'd8);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);

    // stall with A held, B offered
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 1, 4'h3, 5'd10, 64'hAA, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 4'h6, 5'd11, 64'hBB, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("stall_cnt0_5", 64'(sc0), 64'd5);
    chk("stall_cnt1_5", 64'(sc1), 64'd5);
    chk("stall_hold0", od[0], 64'hAA);
    chk("skid_full_ready", 64'(ir[1]), 64'd0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("skid_release_B", od[1], 64'hBB);
    chk("single_empty", 64'(ov[0]), 64'd0);

    // bubble with ctrl all ones
    cyc(1, 0, 0, 4'hF, 5'h1F, 64'h55, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("bubble_ctrl0", 64'(oc[0]), 64'd0);
    chk("bubble_rd1", 64'(orr[1]), 64'd0);

    // flush with MAIN+SKID full and a new beat offered
    cyc(1, 0, 1, 4'h1, 5'd1, 64'h11, 0, 0);
    cyc(1, 0, 1, 4'h2, 5'd2, 64'h22, 0, 0);
    cyc(1, 1, 1, 4'hF, 5'd7, 64'h33, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_valid0", 64'(ov[0]), 64'd0);
    chk("flush_valid1", 64'(ov[1]), 64'd0);
    chk("flush_ready1", 64'(ir[1]), 64'd1);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);

    // saturation, then clear under stall
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 1, 4'h9, 5'd4, 64'h44, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);
    chk("sat_cnt1", 64'(sc1), 64'd15);
    chk("nosat_cnt0", 64'(sc0), 64'd20);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_cnt1", 64'(sc1), 64'd0);
    chk("clr_cnt0", 64'(sc0), 64'd0);

    // reset mid-stall
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_valid0", 64'(ov[0]), 64'd0);
    chk("rst_mid_valid1", 64'(ov[1]), 64'd0);
    chk("rst_mid_cnt1", 64'(sc1), 64'd0);
    chk("rst_mid_ready1", 64'(ir[1]), 64'd1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rc = stage_ctrl_t'($urandom_range(0, 15));
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) != 0),
          rc,
          5'($urandom_range(0, 31)),
          {$urandom, $urandom},
          ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_pipe_stage_reg
